// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit for the execute stage.
// Stalls the pipeline through freeze while an M-op iterates, then holds the result until consumed.
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              flush,
    input  logic              advance,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              freeze,
    output logic              dbz
);
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(ITER - 1);
    localparam logic [DATA_W-1:0] ONES = '1;
    localparam logic [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT               state;
    logic [2:0]          opReg;
    logic [CNT_W-1:0]    counter;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   operand;
    logic                negRes;

    logic                isDiv, isSigned, signA, signB;
    logic [DATA_W-1:0]   absA, absB, shortRes;
    logic                shortCut, shortDbz;

    // Issue-side decode: magnitudes, sign bookkeeping and the cases that skip iteration.
    always_comb begin
        isDiv    = op[2];
        isSigned = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        signA    = isSigned & opa[DATA_W-1];
        signB    = isSigned & opb[DATA_W-1];
        absA     = signA ? -opa : opa;
        absB     = signB ? -opb : opb;
        shortCut = 1'b0;
        shortDbz = 1'b0;
        shortRes = '0;
        if (op == 3'b011) begin
            shortCut = 1'b1;
        end else if (isDiv && (opb == '0)) begin
            shortCut = 1'b1;
            shortDbz = 1'b1;
            shortRes = op[1] ? opa : ONES;
        end else if (((op == 3'b100) || (op == 3'b110)) && (opa == MINV) && (opb == ONES)) begin
            shortCut = 1'b1;
            shortRes = op[1] ? '0 : MINV;
        end
    end

    logic [DATA_W:0]     mulSum, shRem, diff;
    logic [2*DATA_W-1:0] mulNext, divNext, prodFix;
    logic [DATA_W-1:0]   quoFix, remFix, finalRes;

    // acc holds product hi:lo for multiply and remainder:quotient for divide.
    always_comb begin
        mulSum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, operand};
        mulNext = acc[0] ? {mulSum, acc[DATA_W-1:1]}
                         : {1'b0, acc[2*DATA_W-1:DATA_W], acc[DATA_W-1:1]};
        shRem   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        diff    = shRem - {1'b0, operand};
        divNext = diff[DATA_W] ? {shRem[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                               : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        prodFix = negRes ? -mulNext : mulNext;
        quoFix  = negRes ? -divNext[DATA_W-1:0] : divNext[DATA_W-1:0];
        remFix  = negRes ? -divNext[2*DATA_W-1:DATA_W] : divNext[2*DATA_W-1:DATA_W];
        case (opReg)
            3'b000:         finalRes = prodFix[DATA_W-1:0];
            3'b001, 3'b010: finalRes = prodFix[2*DATA_W-1:DATA_W];
            3'b100, 3'b101: finalRes = quoFix;
            3'b110, 3'b111: finalRes = remFix;
            default:        finalRes = '0;
        endcase
    end

    assign busy   = (state == BUSY);
    assign done   = (state == DONE);
    assign freeze = ((state == IDLE) && start && !flush) || (state == BUSY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            opReg   <= '0;
            counter <= '0;
            acc     <= '0;
            operand <= '0;
            negRes  <= 1'b0;
            result  <= '0;
            dbz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        opReg   <= op;
                        counter <= '0;
                        dbz     <= shortDbz;
                        negRes  <= (op == 3'b110) ? signA : (signA ^ signB);
                        acc     <= {{DATA_W{1'b0}}, isDiv ? absA : absB};
                        operand <= isDiv ? absB : absA;
                        if (shortCut) begin
                            result <= shortRes;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc     <= opReg[2] ? divNext : mulNext;
                        counter <= counter + 1'b1;
                        if (counter == LAST) begin
                            result <= finalRes;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Without advance the same M-op is still in EX, so start must not re-issue it.
                    if (flush || advance) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected results queued at issue, popped when done rises.
module tb_ex_muldiv;
    logic        CLK = 1'b0;
    logic        RST, start, flush, advance;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic [31:0] result;
    logic        busy, done, freeze, dbz;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] expQ[$];
    logic [31:0] lastResult;

    ex_muldiv #(.DATA_W(32), .ITER(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa), .opb(opb),
        .flush(flush), .advance(advance), .result(result), .busy(busy),
        .done(done), .freeze(freeze), .dbz(dbz)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        case (o)
            3'b000:  return a * b;
            3'b001: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps[63:32];
            end
            3'b010: begin
                pu = {32'b0, a} * {32'b0, b};
                return pu[63:32];
            end
            3'b100:  return $signed(a) / $signed(b);
            3'b101:  return a / b;
            3'b110:  return $signed(a) % $signed(b);
            3'b111:  return a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output logic f0);
        @(negedge CLK);
        op = o; opa = a; opb = b; start = 1'b1; flush = 1'b0; advance = 1'b0;
        #1 f0 = freeze;
    endtask

    // Bounded wait for done; lat stays -1 on timeout.
    task automatic wait_done(output int lat, output int bc, output int fzBad);
        lat = -1; bc = 0; fzBad = 0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge CLK);
            if (done === 1'b1) lat = c;
            else begin
                if (busy === 1'b1) bc++;
                if (freeze !== 1'b1) fzBad++;
            end
        end
    endtask

    task automatic retire();
        advance = 1'b1; start = 1'b0;
        @(negedge CLK);
        advance = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 0; flush = 0; advance = 0; op = 0; opa = 0; opb = 0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({result, busy, done, dbz, freeze} !== 36'h0)
            begin errors++; $display("FAIL reset_state: got %h required 0", {result, busy, done, dbz, freeze}); end
        RST = 1'b0;
        lastResult = 32'h0;
        @(negedge CLK);
    endtask

    // Multiply and divide share the iterating path; each vector carries its op.
    task automatic test_iterate(input string name, input bit isDivGroup);
        logic [2:0]  vo[7];
        logic [31:0] va[7], vb[7], ve[7];
        logic [32:0] e;
        logic        f0;
        int          lat, bc, fz;
        if (!isDivGroup) begin
            vo[0] = 3'b000; va[0] = 32'd7;         vb[0] = 32'hFFFFFFFD; ve[0] = 32'hFFFFFFEB;
            vo[1] = 3'b001; va[1] = 32'h80000000;  vb[1] = 32'h80000000; ve[1] = 32'h40000000;
            vo[2] = 3'b010; va[2] = 32'hFFFFFFFF;  vb[2] = 32'hFFFFFFFF; ve[2] = 32'hFFFFFFFE;
            vo[3] = 3'b001; va[3] = 32'hFFFFFFFF;  vb[3] = 32'd5;        ve[3] = 32'hFFFFFFFF;
        end else begin
            vo[0] = 3'b101; va[0] = 32'd100;       vb[0] = 32'd7;        ve[0] = 32'd14;
            vo[1] = 3'b111; va[1] = 32'd100;       vb[1] = 32'd7;        ve[1] = 32'd2;
            vo[2] = 3'b100; va[2] = 32'hFFFFFF9C;  vb[2] = 32'd7;        ve[2] = 32'hFFFFFFF2;
            vo[3] = 3'b110; va[3] = 32'hFFFFFF9C;  vb[3] = 32'd7;        ve[3] = 32'hFFFFFFFE;
        end
        for (int i = 4; i < 7; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom >> $urandom_range(0, 31);
            if (isDivGroup) begin
                vo[i] = 3'(4 + $urandom_range(0, 3));
                if (vb[i] == 32'h0) vb[i] = 32'd1;
                if (va[i] == 32'h80000000 && vb[i] == 32'hFFFFFFFF) vb[i] = 32'd3;
            end else begin
                vo[i] = 3'($urandom_range(0, 2));
            end
            ve[i] = model(vo[i], va[i], vb[i]);
        end
        for (int i = 0; i < 7; i++) begin
            issue(vo[i], va[i], vb[i], f0);
            expQ.push_back({1'b0, ve[i]});
            wait_done(lat, bc, fz);
            e = expQ.pop_front();
            checks++;
            if (f0 !== 1'b1) begin errors++; $display("FAIL %s_freeze_issue[%0d]: got %b required 1", name, i, f0); end
            checks++;
            if (lat !== 33) begin errors++; $display("FAIL %s_latency[%0d]: got %0d required 33", name, i, lat); end
            checks++;
            if (result !== e[31:0]) begin errors++; $display("FAIL %s_result[%0d] op=%b a=%h b=%h: got %h required %h", name, i, vo[i], va[i], vb[i], result, e[31:0]); end
            checks++;
            if (dbz !== e[32]) begin errors++; $display("FAIL %s_dbz[%0d]: got %b required %b", name, i, dbz, e[32]); end
            checks++;
            if (bc !== 32 || fz !== 0) begin errors++; $display("FAIL %s_busy_freeze[%0d]: got busy=%0d freezeLow=%0d required 32 0", name, i, bc, fz); end
            checks++;
            if (freeze !== 1'b0) begin errors++; $display("FAIL %s_freeze_done[%0d]: got %b required 0", name, i, freeze); end
            lastResult = e[31:0];
            retire();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_idle[%0d]: got done=%b busy=%b required 0 0", name, i, done, busy); end
        end
    endtask

    task automatic test_short_circuit();
        logic [2:0]  vo[7];
        logic [31:0] va[7], vb[7];
        logic [32:0] ve[7];
        logic [32:0] e;
        logic        f0;
        int          lat, bc, fz;
        vo[0] = 3'b100; va[0] = 32'd5;        vb[0] = 32'h0;        ve[0] = {1'b1, 32'hFFFFFFFF};
        vo[1] = 3'b110; va[1] = 32'd5;        vb[1] = 32'h0;        ve[1] = {1'b1, 32'd5};
        vo[2] = 3'b100; va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; ve[2] = {1'b0, 32'h80000000};
        vo[3] = 3'b110; va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF; ve[3] = {1'b0, 32'h0};
        vo[4] = 3'b011; va[4] = 32'h12345678; vb[4] = 32'h9;        ve[4] = {1'b0, 32'h0};
        vo[5] = 3'b101; va[5] = 32'hDEADBEEF; vb[5] = 32'h0;        ve[5] = {1'b1, 32'hFFFFFFFF};
        vo[6] = 3'b111; va[6] = 32'hDEADBEEF; vb[6] = 32'h0;        ve[6] = {1'b1, 32'hDEADBEEF};
        for (int i = 0; i < 7; i++) begin
            issue(vo[i], va[i], vb[i], f0);
            expQ.push_back(ve[i]);
            wait_done(lat, bc, fz);
            e = expQ.pop_front();
            checks++;
            if (lat !== 1 || bc !== 0) begin errors++; $display("FAIL short_latency[%0d]: got lat=%0d busy=%0d required 1 0", i, lat, bc); end
            checks++;
            if (result !== e[31:0]) begin errors++; $display("FAIL short_result[%0d]: got %h required %h", i, result, e[31:0]); end
            checks++;
            if (dbz !== e[32]) begin errors++; $display("FAIL short_dbz[%0d]: got %b required %b", i, dbz, e[32]); end
            lastResult = e[31:0];
            retire();
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        logic        f0;
        int          lat, bc, fz;
        issue(3'b100, 32'd5, 32'd0, f0);
        expQ.push_back({1'b1, 32'hFFFFFFFF});
        wait_done(lat, bc, fz);
        e = expQ.pop_front();
        checks++;
        if (lat !== 1 || result !== e[31:0] || dbz !== e[32])
            begin errors++; $display("FAIL b2b_first: got lat=%0d res=%h dbz=%b required 1 %h %b", lat, result, dbz, e[31:0], e[32]); end
        // advance with start still high: new op is taken one edge later
        op = 3'b101; opa = 32'd100; opb = 32'd7; advance = 1'b1;
        expQ.push_back({1'b0, 32'd14});
        @(negedge CLK);
        advance = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || freeze !== 1'b1)
            begin errors++; $display("FAIL b2b_gap: got done=%b busy=%b freeze=%b required 0 0 1", done, busy, freeze); end
        wait_done(lat, bc, fz);
        e = expQ.pop_front();
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d required 33", lat); end
        checks++;
        if (result !== e[31:0] || dbz !== e[32])
            begin errors++; $display("FAIL b2b_second: got res=%h dbz=%b required %h %b", result, dbz, e[31:0], e[32]); end
        lastResult = e[31:0];
        retire();
    endtask

    task automatic test_done_stall();
        logic [32:0] e;
        logic        f0;
        int          lat, bc, fz;
        issue(3'b000, 32'd7, 32'hFFFFFFFD, f0);
        expQ.push_back({1'b0, 32'hFFFFFFEB});
        wait_done(lat, bc, fz);
        e = expQ.pop_front();
        checks++;
        if (lat !== 33 || result !== e[31:0]) begin errors++; $display("FAIL stall_first: got lat=%0d res=%h required 33 %h", lat, result, e[31:0]); end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || result !== e[31:0])
                begin errors++; $display("FAIL stall_hold[%0d]: got done=%b busy=%b res=%h required 1 0 %h", k, done, busy, result, e[31:0]); end
        end
        retire();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_advance: got done=%b busy=%b required 0 0", done, busy); end
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, f0);
        expQ.push_back({1'b0, 32'hFFFFFFFE});
        wait_done(lat, bc, fz);
        e = expQ.pop_front();
        checks++;
        if (result !== e[31:0]) begin errors++; $display("FAIL stall_mulhu: got %h required %h", result, e[31:0]); end
        lastResult = e[31:0];
        flush = 1'b1; start = 1'b0;
        @(negedge CLK);
        flush = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== lastResult)
            begin errors++; $display("FAIL done_flush: got done=%b busy=%b res=%h required 0 0 %h", done, busy, result, lastResult); end
    endtask

    task automatic test_flush_reset();
        logic f0;
        int   doneSeen;
        issue(3'b101, 32'd1000, 32'd3, f0);
        repeat (10) @(negedge CLK);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b required 1", busy); end
        flush = 1'b1; start = 1'b0;
        @(negedge CLK);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || freeze !== 1'b0)
            begin errors++; $display("FAIL flush_idle: got busy=%b done=%b freeze=%b required 0 0 0", busy, done, freeze); end
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (done !== 1'b0) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles required 0", doneSeen); end
        checks++;
        if (result !== lastResult) begin errors++; $display("FAIL flush_result_kept: got %h required %h", result, lastResult); end
        issue(3'b100, 32'd5, 32'd0, f0);
        @(negedge CLK);
        start = 1'b0;
        retire();
        issue(3'b001, 32'h80000000, 32'h80000000, f0);
        repeat (5) @(negedge CLK);
        #2 RST = 1'b1; start = 1'b0;
        #1;
        checks++;
        if ({result, busy, done, dbz, freeze} !== 36'h0)
            begin errors++; $display("FAIL async_reset: got %h required 0", {result, busy, done, dbz, freeze}); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b done=%b required 0 0", busy, done); end
    endtask

    initial begin
        test_reset();
        test_iterate("mul", 1'b0);
        test_iterate("div", 1'b1);
        test_short_circuit();
        test_back_to_back();
        test_done_stall();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
